// File: rtl/div_seq_pkg.sv
// Shared MIPS datapath definitions for the sequential divider: widths and FSM state encodings.
package div_seq_pkg;

    localparam int REG_DATA_WIDTH    = 32;
    localparam int DATA_WIDTH        = REG_DATA_WIDTH;
    localparam int DOUBLE_DATA_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_RUN  = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the partial
// remainder and subtracts the divisor when it fits, yielding one quotient bit.
module div_step
    import div_seq_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic [W-1:0] partial_in,
    input  logic         dividend_msb_in,
    input  logic [W-1:0] divisor_in,
    output logic [W-1:0] next_partial_out,
    output logic         q_bit_out
);

    // The shifted value keeps one extra bit so divisors with the MSB set compare correctly.
    logic [W:0]   shifted;
    logic [W-1:0] diff;

    assign shifted          = {partial_in, dividend_msb_in};
    assign diff             = shifted[W-1:0] - divisor_in;
    assign q_bit_out        = (shifted >= {1'b0, divisor_in});
    assign next_partial_out = q_bit_out ? diff : shifted[W-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage; returns {remainder, quotient} for HI/LO.
// Optional DIV_STATS_EN adds div_count_out, a wrapping count of completed divides.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = div_seq_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_in,
    input  logic                    annul_in,
    input  logic                    signed_in,
    input  logic [DATA_WIDTH-1:0]   opdata1_in,
    input  logic [DATA_WIDTH-1:0]   opdata2_in,
    output logic [2*DATA_WIDTH-1:0] result_out,
    output logic                    ready_out,
    output logic                    busy_out
`ifdef DIV_STATS_EN
    ,
    output logic [31:0]             div_count_out
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e                state_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0]     dividend_q;
    logic [DATA_WIDTH-1:0]     divisor_q;
    logic [DATA_WIDTH-1:0]     partial_q;
    logic                      signed_q;
    logic                      neg_dividend_q;
    logic                      neg_divisor_q;
    logic [2*DATA_WIDTH-1:0]   result_q;
    logic                      ready_q;

    logic [DATA_WIDTH-1:0]     abs_dividend_d;
    logic [DATA_WIDTH-1:0]     abs_divisor_d;
    logic [DATA_WIDTH-1:0]     partial_d;
    logic                      q_bit;
    logic [DATA_WIDTH-1:0]     quotient_raw;
    logic [DATA_WIDTH-1:0]     quotient_d;
    logic [DATA_WIDTH-1:0]     remainder_d;
    logic                      accept;
    logic                      finish;

    div_step #(
        .W (DATA_WIDTH)
    ) u_step (
        .partial_in       (partial_q),
        .dividend_msb_in  (dividend_q[DATA_WIDTH-1]),
        .divisor_in       (divisor_q),
        .next_partial_out (partial_d),
        .q_bit_out        (q_bit)
    );

    assign abs_dividend_d = (signed_in && opdata1_in[DATA_WIDTH-1]) ? -opdata1_in : opdata1_in;
    assign abs_divisor_d  = (signed_in && opdata2_in[DATA_WIDTH-1]) ? -opdata2_in : opdata2_in;

    // Quotient bits are shifted into the vacated low end of the dividend register.
    assign quotient_raw = {dividend_q[DATA_WIDTH-2:0], q_bit};
    assign quotient_d   = (signed_q && (neg_dividend_q != neg_divisor_q)) ? -quotient_raw : quotient_raw;
    assign remainder_d  = (signed_q && neg_dividend_q) ? -partial_d : partial_d;

    assign accept = (state_q == DIV_IDLE) && start_in && !annul_in;
    assign finish = (state_q == DIV_ZERO) ||
                    ((state_q == DIV_RUN) && !annul_in && (cnt_q == LAST_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= DIV_IDLE;
            cnt_q          <= '0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            partial_q      <= '0;
            signed_q       <= 1'b0;
            neg_dividend_q <= 1'b0;
            neg_divisor_q  <= 1'b0;
            result_q       <= '0;
            ready_q        <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        if (opdata2_in == '0) begin
                            state_q <= DIV_ZERO;
                        end else begin
                            state_q        <= DIV_RUN;
                            dividend_q     <= abs_dividend_d;
                            divisor_q      <= abs_divisor_d;
                            signed_q       <= signed_in;
                            neg_dividend_q <= opdata1_in[DATA_WIDTH-1];
                            neg_divisor_q  <= opdata2_in[DATA_WIDTH-1];
                            cnt_q          <= '0;
                            partial_q      <= '0;
                        end
                    end
                end
                DIV_ZERO: begin
                    state_q  <= DIV_DONE;
                    result_q <= '0;
                    ready_q  <= 1'b1;
                end
                DIV_RUN: begin
                    if (annul_in) begin
                        state_q <= DIV_IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        partial_q  <= partial_d;
                        dividend_q <= quotient_raw;
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q  <= DIV_DONE;
                            result_q <= {remainder_d, quotient_d};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    if (annul_in || !start_in) begin
                        state_q <= DIV_IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_STATS_EN
    logic [31:0] div_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_count_q <= '0;
        end else if (finish) begin
            div_count_q <= div_count_q + 32'd1;
        end
    end

    assign div_count_out = div_count_q;
`endif

    assign result_out = result_q;
    assign ready_out  = ready_q;
    assign busy_out   = accept || (state_q == DIV_ZERO) || (state_q == DIV_RUN);

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, signed/unsigned results, divide-by-zero, annul, async reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        annul_in;
    logic        signed_in;
    logic [31:0] opdata1_in;
    logic [31:0] opdata2_in;
    logic [63:0] result_out;
    logic        ready_out;
    logic        busy_out;
`ifdef DIV_STATS_EN
    logic [31:0] div_count_out;
`endif

    int checks   = 0;
    int failures = 0;
    int completed = 0;

    div_seq u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .annul_in   (annul_in),
        .signed_in  (signed_in),
        .opdata1_in (opdata1_in),
        .opdata2_in (opdata2_in),
        .result_out (result_out),
        .ready_out  (ready_out),
        .busy_out   (busy_out)
`ifdef DIV_STATS_EN
        ,
        .div_count_out (div_count_out)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Issue one divide, count edges until ready, then release start and confirm return to IDLE.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input int exp_lat);
        int   edges;
        logic busy_ok;
        @(negedge clk);
        opdata1_in = a;
        opdata2_in = b;
        signed_in  = s;
        start_in   = 1'b1;
        #1;
        check_eq({tag, "_busy_req"}, 64'(busy_out), 64'd1);
        edges   = 0;
        busy_ok = 1'b1;
        while (!ready_out && edges < 100) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                opdata1_in = ~a;
                opdata2_in = 32'h0;
            end
            if (!ready_out && !busy_out) busy_ok = 1'b0;
        end
        check_eq({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check_eq({tag, "_result"}, result_out, exp);
        check_eq({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check_eq({tag, "_busy_done"}, 64'(busy_out), 64'd0);
        completed++;
        start_in = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ready_clr"}, 64'(ready_out), 64'd0);
        check_eq({tag, "_held"}, result_out, exp);
    endtask

    initial begin
        logic [63:0] prev;
        rst        = 1'b1;
        start_in   = 1'b0;
        annul_in   = 1'b0;
        signed_in  = 1'b0;
        opdata1_in = 32'h0;
        opdata2_in = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_result", result_out, 64'h0);
        check_eq("rst_ready", 64'(ready_out), 64'd0);
        check_eq("rst_busy", 64'(busy_out), 64'd0);
`ifdef DIV_STATS_EN
        check_eq("rst_count", 64'(div_count_out), 64'd0);
`endif
        rst = 1'b0;

        run_div("u100_7",   32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33);
        run_div("s_m7_2",   32'hFFFFFFF9,   32'h2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s_7_m2",   32'h7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33);
        run_div("u_big",    32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, 64'h00000001_00000001, 33);
        run_div("u_msb",    32'hFFFFFFFF,   32'h80000001,   1'b0, 64'h7FFFFFFE_00000001, 33);
        run_div("u_hex",    32'h12345678,   32'h1000,       1'b0, 64'h00000678_00012345, 33);

        // Divide by zero with start held for three extra cycles in DONE.
        @(negedge clk);
        opdata1_in = 32'd5;
        opdata2_in = 32'd0;
        signed_in  = 1'b0;
        start_in   = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("dz_ready", 64'(ready_out), 64'd1);
        check_eq("dz_result", result_out, 64'h0);
        completed++;
        repeat (3) @(negedge clk);
        check_eq("dz_hold_ready", 64'(ready_out), 64'd1);
        check_eq("dz_hold_busy", 64'(busy_out), 64'd0);
        start_in = 1'b0;
        @(negedge clk);
        check_eq("dz_idle_ready", 64'(ready_out), 64'd0);

        // Seed a nonzero result so the annul and reset checks can see a change.
        run_div("u_seed",   32'd50,         32'd7,          1'b0, 64'h00000001_00000007, 33);
        prev = result_out;

        // Annul at iteration 10 of 0xFFFFFFFF/3.
        @(negedge clk);
        opdata1_in = 32'hFFFFFFFF;
        opdata2_in = 32'd3;
        start_in   = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        annul_in = 1'b1;
        start_in = 1'b0;
        @(negedge clk);
        annul_in = 1'b0;
        check_eq("annul_busy", 64'(busy_out), 64'd0);
        check_eq("annul_ready", 64'(ready_out), 64'd0);
        repeat (30) @(negedge clk);
        check_eq("annul_no_ready", 64'(ready_out), 64'd0);
        check_eq("annul_result_held", result_out, prev);
        run_div("u9_3",     32'd9,          32'd3,          1'b0, 64'h00000000_00000003, 33);

        // Asynchronous reset at iteration 20.
        @(negedge clk);
        opdata1_in = 32'h12345678;
        opdata2_in = 32'd3;
        start_in   = 1'b1;
        repeat (21) @(negedge clk);
        #2;
        start_in = 1'b0;
        rst      = 1'b1;
        #1;
        check_eq("arst_ready", 64'(ready_out), 64'd0);
        check_eq("arst_result", result_out, 64'h0);
        check_eq("arst_busy", 64'(busy_out), 64'd0);
        completed = 0;
        @(negedge clk);
        rst = 1'b0;

        run_div("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33);
        run_div("s_m100_m7",32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 64'hFFFFFFFE_0000000E, 33);

        // Annulled divide after reset must not be counted.
        @(negedge clk);
        opdata1_in = 32'd1000;
        opdata2_in = 32'd3;
        start_in   = 1'b1;
        repeat (5) @(negedge clk);
        annul_in = 1'b1;
        start_in = 1'b0;
        @(negedge clk);
        annul_in = 1'b0;
        check_eq("annul2_busy", 64'(busy_out), 64'd0);

        run_div("u_last",   32'd1000,       32'd3,          1'b0, 64'h00000001_0000014D, 33);
`ifdef DIV_STATS_EN
        check_eq("stats_count", 64'(div_count_out), 64'(completed));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the DIV/DIVU datapath in the MIPS EX stage.
- Accepts one divide request from ex and runs a restoring shift-subtract loop that produces one quotient bit per cycle.
- Returns {remainder, quotient} for the HI/LO path.
- Drives a busy signal that ex forwards to ctrl as its stall request, holding IF/ID/EX until the result is ready.

Parameters:
- DATA_WIDTH, 32, operand width; result is 2*DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  divide request from ex; held high until ready_out is seen.
- annul_in  in  1  cancel the in-flight divide (pipeline flush).
- signed_in  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_in  in  DATA_WIDTH  dividend.
- opdata2_in  in  DATA_WIDTH  divisor.
- result_out  out  2*DATA_WIDTH  [2W-1:W] remainder (HI), [W-1:0] quotient (LO).
- ready_out  out  1  result valid (registered).
- busy_out  out  1  stall request to ctrl (combinational).

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE, cnt=0, ready_out=0, result_out=0, internal dividend/divisor/partial remainder=0.
- States: IDLE, DIV_ZERO, RUN, DONE.
- IDLE:
  - start_in=1, annul_in=0, opdata2_in==0 → DIV_ZERO.
  - start_in=1, annul_in=0, opdata2_in!=0 → RUN.
  - In the RUN case, latch operands (absolute values when signed_in=1), the sign flags and signed_in; set cnt=0 and partial remainder=0.
  - Otherwise stay in IDLE.
- DIV_ZERO: next edge → DONE with result_out=0.
- RUN:
  - Each edge: partial = {partial[W-2:0], dividend_msb}; dividend shifts left.
  - If partial ≥ divisor: subtract and shift in quotient bit 1; else shift in 0.
  - cnt increments each edge.
  - When cnt==W-1 at an edge: → DONE, register the final result (sign-corrected) into result_out, set ready_out=1.
  - annul_in=1 at any RUN edge → IDLE, ready_out stays 0, no result update.
- DONE:
  - ready_out=1 and result_out are held.
  - start_in=0 at an edge → IDLE, ready_out=0; result_out is held until the next completion.
  - annul_in=1 → IDLE.
- Latency: start sampled at edge E0; ready_out high after edge E_W, i.e. W+1 edges including the sampling edge. Divide-by-zero: ready_out high after 2 edges.
- Sign correction:
  - Quotient is negated iff signed_in and dividend sign ≠ divisor sign.
  - Remainder is negated iff signed_in and dividend is negative.
  - -2^(W-1) / -1 yields quotient 0x8000_0000 and remainder 0 (no trap).
- busy_out = (IDLE & start_in & ~annul_in) | DIV_ZERO | RUN. It is 0 in DONE so the pipeline can advance the same cycle ex consumes the result.
- Simultaneous start_in and annul_in in IDLE: annul wins; stay in IDLE.
- Operand changes after the sampling edge are ignored.

Optional Feature:
- Macro: DIV_STATS_EN.
- Defined:
  - Adds output port div_count_out (32 bits): count of completed divides (entries into DONE). Annulled divides are not counted.
  - Counter wraps at 2^32. Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (mips defines) holds:
  - DIV_IDLE/DIV_ZERO/DIV_RUN/DIV_DONE state encodings (2 bits).
  - DATA_WIDTH default, aligned with REG_DATA_WIDTH.
  - DOUBLE_DATA_WIDTH.
- One natural combinational sub-module: div_step. Inputs partial, dividend_msb, divisor; outputs next_partial and q_bit. div_seq instantiates it once.

Test Plan:
- Unsigned divide, signed_in=0, 100/7 → after 33 edges ready_out=1, result_out=0x00000002_0000000E; busy_out=1 for the whole run.
- Signed divide, signed_in=1, -7/2 (0xFFFFFFF9/0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also check 7/-2 → quotient 0xFFFFFFFD, remainder 0x1.
- Divide by zero, 5/0 → ready_out after 2 edges, result_out=0; start_in held for 3 cycles → stays in DONE, then IDLE after start_in=0.
- Annul, with annul_in pulsed at iteration 10 of 0xFFFFFFFF/3 → IDLE next edge, ready_out never rises, busy_out=0. A following 9/3 completes with 0x0_00000003.
- Reset mid-run, with rst asserted asynchronously at iteration 20 → immediate ready_out=0, result_out=0, busy_out=0. Overflow case 0x80000000/0xFFFFFFFF signed → 0x00000000_80000000.
- Stats (DIV_STATS_EN), with 3 completed divides plus 1 annulled → div_count_out=3.
